// File: rtl/aggregator_arbiter_if.sv
// Sender/receiver bundle for aggregator_arbiter.
// receiver_partial exists only when AGG_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
interface aggregator_arbiter_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int NUM_SENDERS = 4,
    parameter int ID_WIDTH    = 2
);
    logic [NUM_SENDERS*DATA_WIDTH-1:0] sender_data;
    logic [NUM_SENDERS-1:0]            sender_empty_n;
    logic [NUM_SENDERS-1:0]            sender_deq;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data;
    logic [ID_WIDTH-1:0]               receiver_id;
    logic                              receiver_full_n;
    logic                              receiver_enq;
    logic                              busy;
`ifdef AGG_ARB_TIMEOUT_EN
    logic                              receiver_partial;

    modport master (
        input  sender_data, sender_empty_n, receiver_full_n,
        output sender_deq, receiver_data, receiver_id, receiver_enq, busy, receiver_partial
    );
    modport slave (
        output sender_data, sender_empty_n, receiver_full_n,
        input  sender_deq, receiver_data, receiver_id, receiver_enq, busy, receiver_partial
    );
`else
    modport master (
        input  sender_data, sender_empty_n, receiver_full_n,
        output sender_deq, receiver_data, receiver_id, receiver_enq, busy
    );
    modport slave (
        output sender_data, sender_empty_n, receiver_full_n,
        input  sender_deq, receiver_data, receiver_id, receiver_enq, busy
    );
`endif
endinterface

// File: rtl/aggregator_arbiter.sv
// Round-robin arbiter packing FETCH_WIDTH words from one show-ahead FIFO per burst.
// Optional partial-burst flush on idle timeout: define AGG_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module aggregator_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int NUM_SENDERS = 4,
    parameter int ID_WIDTH    = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    aggregator_arbiter_if.master bus
);
    localparam int CNT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    if (ID_WIDTH < $clog2(NUM_SENDERS) || FETCH_WIDTH < 1 || NUM_SENDERS < 2 || TIMEOUT < 1)
    begin : g_param_check
        $error("aggregator_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

    state_t                                 state_q, state_d;
    logic [ID_WIDTH-1:0]                    grant_q, grant_d;
    logic [ID_WIDTH-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]                    id_q, id_d;
    logic [CNT_W-1:0]                       count_q, count_d;
    logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] lane_q, lane_d;

    logic                  found;
    logic [ID_WIDTH-1:0]   pick;
    int                    idx;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;

`ifdef AGG_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              partial_q, partial_d;
`endif

    // First non-empty sender at or after rr_ptr; descending scan leaves the nearest one.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = 0;
        for (int k = NUM_SENDERS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_SENDERS;
            if (bus.sender_empty_n[idx]) begin
                found = 1'b1;
                pick  = ID_WIDTH'(idx);
            end
        end
    end

    assign head = bus.sender_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign pop  = (state_q == COLLECT) && bus.sender_empty_n[grant_q];

    always_comb begin
        bus.sender_deq          = '0;
        bus.sender_deq[grant_q] = pop;
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        id_d             = id_q;
        count_d          = count_q;
        lane_d           = lane_q;
        bus.receiver_enq = 1'b0;
`ifdef AGG_ARB_TIMEOUT_EN
        idle_d           = idle_q;
        partial_d        = partial_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = pick;
                    rr_ptr_d = (pick == ID_WIDTH'(NUM_SENDERS - 1)) ? '0 : pick + ID_WIDTH'(1);
                    state_d  = COLLECT;
`ifdef AGG_ARB_TIMEOUT_EN
                    idle_d   = '0;
`endif
                end
            end
            COLLECT: begin
                if (pop) begin
                    lane_d[count_q] = head;
                    if (count_q == CNT_W'(FETCH_WIDTH - 1)) begin
                        count_d = '0;
                        id_d    = grant_q;
                        state_d = SEND;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
`ifdef AGG_ARB_TIMEOUT_EN
                    idle_d = '0;
                end else if (count_q != '0 && idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    // Flush what we have; lanes not yet written go out as zero.
                    for (int k = 0; k < FETCH_WIDTH; k++)
                        if (k >= int'(count_q)) lane_d[k] = '0;
                    count_d   = '0;
                    id_d      = grant_q;
                    idle_d    = '0;
                    partial_d = 1'b1;
                    state_d   = SEND;
                end else if (idle_q < IDLE_W'(TIMEOUT - 1)) begin
                    idle_d = idle_q + IDLE_W'(1);
`endif
                end
            end
            SEND: begin
                bus.receiver_enq = bus.receiver_full_n;
                if (bus.receiver_full_n) begin
                    state_d = IDLE;
`ifdef AGG_ARB_TIMEOUT_EN
                    partial_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            count_q   <= '0;
            lane_q    <= '0;
`ifdef AGG_ARB_TIMEOUT_EN
            idle_q    <= '0;
            partial_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            count_q   <= count_d;
            lane_q    <= lane_d;
`ifdef AGG_ARB_TIMEOUT_EN
            idle_q    <= idle_d;
            partial_q <= partial_d;
`endif
        end
    end

    assign bus.receiver_data = lane_q;
    assign bus.receiver_id   = id_q;
    assign bus.busy          = (state_q != IDLE);
`ifdef AGG_ARB_TIMEOUT_EN
    assign bus.receiver_partial = partial_q;
`endif
endmodule

// File: tb/tb_aggregator_arbiter.sv
// Randomized + directed bench for aggregator_arbiter: per-sender word streams
// feed a scoreboard; a negedge monitor compares every cycle against a spec-level model.
`timescale 1ns/1ps
module tb_aggregator_arbiter;
    localparam int DW = 8, F = 2, NS = 4, IW = 2;

    logic clk, rst;
    aggregator_arbiter_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(F), .NUM_SENDERS(NS), .ID_WIDTH(IW)) ifc ();
    aggregator_arbiter #(.DATA_WIDTH(DW), .FETCH_WIDTH(F), .NUM_SENDERS(NS), .ID_WIDTH(IW), .TIMEOUT(16))
        dut (.clk(clk), .rst(rst), .bus(ifc.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [IW-1:0] id; logic [F*DW-1:0] data; } enq_t;

    logic [DW-1:0] fifo [NS][$];   // contents of each sender FIFO
    logic [DW-1:0] exp_q [NS][$];  // words pushed but not yet delivered in a burst
    enq_t          log_q [$];
    int            errors = 0, checks = 0;
    int            m_cur = -1, m_got = 0, m_rr = 0, m_stall = 0;
    logic [NS-1:0] deq_s = '0, exp_deq;
    logic          full_n_k = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [F*DW-1:0] pack(input int s);
        logic [F*DW-1:0] v = '0;
        for (int k = 0; k < F; k++)
            if (k < exp_q[s].size()) v[k*DW +: DW] = exp_q[s][k];
        return v;
    endfunction

    task automatic push(input int s, input logic [DW-1:0] v);
        fifo[s].push_back(v);
        exp_q[s].push_back(v);
    endtask

    // One clock: retire words the DUT popped at this edge, then present new FIFO heads.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (deq_s[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        for (int i = 0; i < NS; i++) begin
            ifc.sender_empty_n[i]          = (fifo[i].size() > 0);
            ifc.sender_data[i*DW +: DW]    = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
        ifc.receiver_full_n = full_n_k;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Monitor: model state is (granted sender or none, words popped so far, round-robin start).
    initial forever begin
        @(negedge clk);
        deq_s = ifc.sender_deq;
        if (rst) begin
            chk("rst_deq", 32'(ifc.sender_deq), 0);
            chk("rst_enq", 32'(ifc.receiver_enq), 0);
            chk("rst_busy", 32'(ifc.busy), 0);
            if (m_cur >= 0)
                repeat (m_got) if (exp_q[m_cur].size() > 0) void'(exp_q[m_cur].pop_front());
            m_cur = -1; m_got = 0; m_rr = 0;
        end else if (m_cur < 0) begin
            chk("idle_busy", 32'(ifc.busy), 0);
            chk("idle_deq", 32'(ifc.sender_deq), 0);
            chk("idle_enq", 32'(ifc.receiver_enq), 0);
            for (int k = 0; k < NS; k++)
                if (m_cur < 0 && ifc.sender_empty_n[(m_rr + k) % NS]) m_cur = (m_rr + k) % NS;
            if (m_cur >= 0) begin
                m_rr  = (m_cur + 1) % NS;
                m_got = 0;
            end
        end else if (m_got < F) begin
            exp_deq        = '0;
            exp_deq[m_cur] = ifc.sender_empty_n[m_cur];
            chk("collect_deq", 32'(ifc.sender_deq), 32'(exp_deq));
            chk("collect_enq", 32'(ifc.receiver_enq), 0);
            chk("collect_busy", 32'(ifc.busy), 1);
            if (ifc.sender_deq != '0) m_got++;
        end else begin
            chk("send_deq", 32'(ifc.sender_deq), 0);
            chk("send_busy", 32'(ifc.busy), 1);
            chk("send_enq", 32'(ifc.receiver_enq), 32'(ifc.receiver_full_n));
            chk("send_data", 32'(ifc.receiver_data), 32'(pack(m_cur)));
            chk("send_id", 32'(ifc.receiver_id), 32'(m_cur));
            if (!ifc.receiver_full_n) m_stall++;
            if (ifc.receiver_enq) log_q.push_back('{id: ifc.receiver_id, data: ifc.receiver_data});
            if (ifc.receiver_full_n) begin
                repeat (F) if (exp_q[m_cur].size() > 0) void'(exp_q[m_cur].pop_front());
                m_cur = -1;
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifc.sender_empty_n  = '0;
        ifc.sender_data     = '0;
        ifc.receiver_full_n = 1'b1;
        run(3);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_data", 32'(ifc.receiver_data), 0);
        chk("post_rst_id", 32'(ifc.receiver_id), 0);
        chk("post_rst_busy", 32'(ifc.busy), 0);
        chk("post_rst_deq", 32'(ifc.sender_deq), 0);
        chk("post_rst_enq", 32'(ifc.receiver_enq), 0);

        // Single sender 2, four words -> two bursts
        log_q.delete();
        for (int i = 0; i < 4; i++) push(2, 8'h10 + 8'(i));
        run(12);
        chk("single_nbursts", 32'(log_q.size()), 2);
        if (log_q.size() >= 2) begin
            chk("single_d0", 32'(log_q[0].data), 32'h1110);
            chk("single_id0", 32'(log_q[0].id), 2);
            chk("single_d1", 32'(log_q[1].data), 32'h1312);
            chk("single_id1", 32'(log_q[1].id), 2);
        end

        // Starved grant: sender 1 gives one word, sender 3 waits behind it
        log_q.delete();
        push(1, 8'h21);
        for (int n = 0; n < 20 && !(m_cur == 1 && m_got == 1); n++) cycle();
        chk("starve_granted", 32'(m_cur == 1 && m_got == 1), 1);
        for (int i = 0; i < 4; i++) push(3, 8'h40 + 8'(i));
        run(8);
        chk("starve_no_enq", 32'(log_q.size()), 0);
        push(1, 8'h22);
        run(16);
        chk("starve_nbursts", 32'(log_q.size()), 3);
        if (log_q.size() >= 1) begin
            chk("starve_id", 32'(log_q[0].id), 1);
            chk("starve_data", 32'(log_q[0].data), 32'h2221);
        end

        // Reset after one word of a burst has been popped
        log_q.delete();
        push(0, 8'h30); push(0, 8'h31); push(0, 8'h32);
        for (int n = 0; n < 20 && !(m_cur == 0 && m_got == 1); n++) cycle();
        chk("midrst_reached", 32'(m_cur == 0 && m_got == 1), 1);
        pulse_rst();
        @(negedge clk);
        chk("midrst_busy", 32'(ifc.busy), 0);
        run(12);
        chk("midrst_nbursts", 32'(log_q.size()), 1);
        if (log_q.size() >= 1) begin
            chk("midrst_data", 32'(log_q[0].data), 32'h3231);
            chk("midrst_id", 32'(log_q[0].id), 0);
        end

        // Back-pressure held in SEND
        log_q.delete();
        m_stall  = 0;
        full_n_k = 1'b0;
        push(2, 8'h50); push(2, 8'h51);
        run(15);
        chk("bp_no_enq", 32'(log_q.size()), 0);
        chk("bp_stalled", 32'(m_stall >= 10), 1);
        full_n_k = 1'b1;
        run(4);
        chk("bp_one_enq", 32'(log_q.size()), 1);
        if (log_q.size() >= 1) chk("bp_data", 32'(log_q[0].data), 32'h5150);

        // Round-robin with every sender kept non-empty
        pulse_rst();
        log_q.delete();
        for (int i = 0; i < NS; i++) begin
            push(i, 8'($urandom)); push(i, 8'($urandom));
        end
        for (int n = 0; n < 100 && log_q.size() < 5; n++) begin
            cycle();
            for (int i = 0; i < NS; i++)
                if (fifo[i].size() < 2) push(i, 8'($urandom));
        end
        chk("rr_nbursts", 32'(log_q.size() >= 5), 1);
        for (int k = 0; k < 5 && k < log_q.size(); k++)
            chk("rr_order", 32'(log_q[k].id), 32'(k % NS));

        // Random traffic, back-pressure and occasional resets
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 2) == 0 && fifo[i].size() < 6) push(i, 8'($urandom));
            full_n_k = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) pulse_rst();
            else cycle();
        end

        // Drain: top each stream up to whole bursts and let everything go out
        full_n_k = 1'b1;
        for (int i = 0; i < NS; i++)
            while (exp_q[i].size() % F != 0) push(i, 8'($urandom));
        for (int n = 0; n < 500 && (m_cur >= 0 || exp_q[0].size() + exp_q[1].size()
                                    + exp_q[2].size() + exp_q[3].size() != 0); n++) cycle();
        for (int i = 0; i < NS; i++) chk("drain_left", 32'(exp_q[i].size()), 0);
        @(negedge clk);
        chk("drain_busy", 32'(ifc.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
